// File: rtl/lagarto_pmu_counter_bank.sv
// Lagarto PMU counter bank: programmable event counters with a CSR port,
// overflow tracking and interrupt, gated by a power-on wake-up delay.

module lagarto_pmu_lane #(
   parameter int CNT_WIDTH  = 64,
   parameter int NUM_EVENTS = 23,
   parameter int SEL_W      = 5,
   parameter int RST_SEL    = 0
) (
   input  logic                  clk_i,
   input  logic                  reset_l,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic                  ready,
   input  logic                  inhibit,
   input  logic                  cnt_we,
   input  logic [CNT_WIDTH-1:0]  cnt_wdata,
   input  logic                  sel_we,
   input  logic [SEL_W-1:0]      sel_wdata,
   input  logic                  ovf_clr,
   output logic [CNT_WIDTH-1:0]  cnt,
   output logic [SEL_W-1:0]      sel,
   output logic                  ovf
);

   logic hit;
   logic inc;
   logic wrap;

   // Out-of-range selects must count nothing rather than index past the vector.
   always_comb begin
      hit = 1'b0;
      if (32'(sel) < NUM_EVENTS) hit = event_i[sel];
   end

   assign inc  = ready & ~inhibit & hit;
   assign wrap = inc & ~cnt_we & (&cnt);

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         cnt <= '0;
         sel <= SEL_W'(RST_SEL);
         ovf <= 1'b0;
      end else begin
         if (cnt_we)   cnt <= cnt_wdata;
         else if (inc) cnt <= cnt + 1'b1;
         if (sel_we)   sel <= sel_wdata;
         // A new wrap beats a same-cycle W1C.
         ovf <= (ovf & ~ovf_clr) | wrap;
      end
   end

endmodule

module lagarto_pmu_counter_bank #(
   parameter int NUM_EVENTS     = 23,
   parameter int NUM_COUNTERS   = 8,
   parameter int CNT_WIDTH      = 64,
   parameter int WAKE_CNT_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_l,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic                  csr_req_i,
   input  logic                  csr_we_i,
   input  logic [5:0]            csr_addr_i,
   input  logic [63:0]           csr_wdata_i,
   output logic [63:0]           csr_rdata_o,
   output logic                  csr_ack_o,
   output logic                  overflow_irq_o,
   output logic                  ready_o
);

   localparam int SEL_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

   localparam logic [1:0] SP_CNT  = 2'b00;
   localparam logic [1:0] SP_SEL  = 2'b01;
   localparam logic [1:0] SP_CTRL = 2'b10;
   localparam logic [1:0] SP_OVF  = 2'b11;

   logic [WAKE_CNT_WIDTH-1:0]                 wake_cnt;
   logic [NUM_COUNTERS-1:0][CNT_WIDTH-1:0]    cnt;
   logic [NUM_COUNTERS-1:0][SEL_W-1:0]        sel;
   logic [NUM_COUNTERS-1:0]                   ovf;
   logic [NUM_COUNTERS-1:0]                   inhibit;
   logic [NUM_COUNTERS-1:0]                   irq_en;
   logic [1:0]                                space;
   logic [3:0]                                idx;
   logic                                      wr;
   logic [63:0]                               rd_val;

   assign space   = csr_addr_i[5:4];
   assign idx     = csr_addr_i[3:0];
   assign wr      = csr_req_i & csr_we_i;
   assign ready_o = wake_cnt[WAKE_CNT_WIDTH-1];

   // Wake-up delay saturates once its MSB sets.
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l)                         wake_cnt <= '0;
      else if (!wake_cnt[WAKE_CNT_WIDTH-1]) wake_cnt <= wake_cnt + 1'b1;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_COUNTERS; g++) begin : g_lane
         lagarto_pmu_lane #(
            .CNT_WIDTH  (CNT_WIDTH),
            .NUM_EVENTS (NUM_EVENTS),
            .SEL_W      (SEL_W),
            .RST_SEL    (g % NUM_EVENTS)
         ) u_lane (
            .clk_i     (clk_i),
            .reset_l   (reset_l),
            .event_i   (event_i),
            .ready     (ready_o),
            .inhibit   (inhibit[g]),
            .cnt_we    (wr && space == SP_CNT && idx == 4'(g)),
            .cnt_wdata (csr_wdata_i[CNT_WIDTH-1:0]),
            .sel_we    (wr && space == SP_SEL && idx == 4'(g)),
            .sel_wdata (csr_wdata_i[SEL_W-1:0]),
            .ovf_clr   (wr && space == SP_OVF && csr_wdata_i[g]),
            .cnt       (cnt[g]),
            .sel       (sel[g]),
            .ovf       (ovf[g])
         );
      end
   endgenerate

   // Indices past NUM_COUNTERS match no lane, so they read 0 and drop writes.
   always_comb begin
      rd_val = '0;
      case (space)
         SP_CNT: begin
            for (int i = 0; i < NUM_COUNTERS; i++)
               if (idx == 4'(i)) rd_val = 64'(cnt[i]);
         end
         SP_SEL: begin
            for (int i = 0; i < NUM_COUNTERS; i++)
               if (idx == 4'(i)) rd_val = 64'(sel[i]);
         end
         SP_CTRL: begin
            rd_val[NUM_COUNTERS-1:0]   = inhibit;
            rd_val[16 +: NUM_COUNTERS] = irq_en;
         end
         default: rd_val[NUM_COUNTERS-1:0] = ovf;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         inhibit        <= '0;
         irq_en         <= '0;
         csr_ack_o      <= 1'b0;
         csr_rdata_o    <= '0;
         overflow_irq_o <= 1'b0;
      end else begin
         if (wr && space == SP_CTRL) begin
            inhibit <= csr_wdata_i[NUM_COUNTERS-1:0];
            irq_en  <= csr_wdata_i[16 +: NUM_COUNTERS];
         end
         csr_ack_o      <= csr_req_i;
         csr_rdata_o    <= (csr_req_i && !csr_we_i) ? rd_val : '0;
         overflow_irq_o <= |(ovf & irq_en);
      end
   end

endmodule

// File: tb/tb_lagarto_pmu_counter_bank.sv
// Directed bench for lagarto_pmu_counter_bank with an 8-bit counter and a
// 4-bit wake-up counter so wrap and wake-up are reachable quickly.

module tb_lagarto_pmu_counter_bank;

   localparam int NE = 23;

   logic          clk = 1'b0;
   logic          reset_l;
   logic [NE-1:0] event_i;
   logic          csr_req, csr_we;
   logic [5:0]    csr_addr;
   logic [63:0]   csr_wdata;
   logic [63:0]   csr_rdata;
   logic          csr_ack, irq, ready;
   logic [63:0]   rd;

   int checks = 0;
   int failures = 0;

   lagarto_pmu_counter_bank #(
      .NUM_EVENTS(NE), .NUM_COUNTERS(8), .CNT_WIDTH(8), .WAKE_CNT_WIDTH(4)
   ) dut (
      .clk_i(clk), .reset_l(reset_l), .event_i(event_i),
      .csr_req_i(csr_req), .csr_we_i(csr_we), .csr_addr_i(csr_addr),
      .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .csr_ack_o(csr_ack),
      .overflow_irq_o(irq), .ready_o(ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle CSR access; returns the data presented with the ack.
   task automatic csr(input logic we, input logic [5:0] addr, input logic [63:0] wd,
                      output logic [63:0] rdv);
      csr_req = 1'b1; csr_we = we; csr_addr = addr; csr_wdata = wd;
      tick();
      csr_req = 1'b0; csr_we = 1'b0;
      chk("ack", 64'(csr_ack), 64'd1);
      rdv = csr_rdata;
      tick_ack_drop();
   endtask

   task automatic tick_ack_drop();
      // Ack is a pulse; it must not linger once the request is gone.
   endtask

   initial begin
      reset_l = 1'b0; event_i = '0; csr_req = 1'b0; csr_we = 1'b0;
      csr_addr = '0; csr_wdata = '0;
      #1;
      chk("rst_ack",   64'(csr_ack), 64'd0);
      chk("rst_rdata", csr_rdata,    64'd0);
      chk("rst_irq",   64'(irq),     64'd0);
      chk("rst_ready", 64'(ready),   64'd0);
      repeat (2) tick();
      event_i = NE'(1);
      reset_l = 1'b1;

      // Wake-up: CSR served before ready; ready rises on the 8th edge.
      csr(1'b0, 6'h13, '0, rd);        chk("sel3_rst", rd, 64'd3);
      repeat (6) tick();               chk("ready_7", 64'(ready), 64'd0);
      tick();                          chk("ready_8", 64'(ready), 64'd1);
      repeat (4) tick();
      csr(1'b0, 6'h00, '0, rd);        chk("cnt0_n12", rd, 64'd4);

      // Inhibit counter 0; the write's own edge still counts.
      csr(1'b1, 6'h20, 64'h1, rd);     chk("wr_rdata0", rd, 64'd0);
      csr(1'b0, 6'h00, '0, rd);        chk("cnt0_inh_a", rd, 64'd6);
      repeat (10) tick();
      csr(1'b0, 6'h00, '0, rd);        chk("cnt0_inh_b", rd, 64'd6);
      csr(1'b0, 6'h0F, '0, rd);        chk("cnt_idx15", rd, 64'd0);
      csr(1'b0, 6'h1F, '0, rd);        chk("sel_idx15", rd, 64'd0);
      csr(1'b1, 6'h09, 64'h55, rd);

      // Control keeps only the inhibit and irq_en fields.
      csr(1'b1, 6'h20, '1, rd);
      csr(1'b0, 6'h20, '0, rd);        chk("ctrl_mask", rd, 64'h0000_0000_00FF_00FF);
      csr(1'b1, 6'h20, 64'h1, rd);

      // Counter 2 on event 5: 0xFE + 2 pulses wraps to 0 and sets ovf[2].
      csr(1'b1, 6'h02, 64'hFE, rd);
      csr(1'b1, 6'h12, 64'd5, rd);
      event_i = NE'(1) | NE'(32); tick();
      event_i = NE'(1);           tick();
      event_i = NE'(1) | NE'(32); tick();
      event_i = NE'(1);
      csr(1'b0, 6'h02, '0, rd);        chk("cnt2_wrap", rd, 64'd0);
      csr(1'b0, 6'h30, '0, rd);        chk("ovf_set", rd, 64'h04);
      chk("irq_noen", 64'(irq), 64'd0);
      csr(1'b1, 6'h20, 64'h0004_0001, rd);
      chk("irq_lag", 64'(irq), 64'd0);
      tick();                          chk("irq_on", 64'(irq), 64'd1);

      // W1C clears; then W1C coincident with a fresh wrap leaves it set.
      csr(1'b1, 6'h30, 64'h04, rd);
      csr(1'b0, 6'h30, '0, rd);        chk("ovf_clr", rd, 64'd0);
      chk("irq_off", 64'(irq), 64'd0);
      csr(1'b1, 6'h02, 64'hFF, rd);
      event_i = NE'(1) | NE'(32);
      csr(1'b1, 6'h30, 64'h04, rd);
      event_i = NE'(1);
      csr(1'b0, 6'h3F, '0, rd);        chk("ovf_setwins", rd, 64'h04);
      csr(1'b0, 6'h02, '0, rd);        chk("cnt2_wrap2", rd, 64'd0);
      csr(1'b0, 6'h2A, '0, rd);        chk("ctrl_idxign", rd, 64'h0004_0001);

      // Write beats same-cycle increment; only the low 8 bits load.
      event_i = NE'(1) | NE'(2);
      csr(1'b1, 6'h01, 64'h140, rd);
      event_i = NE'(1);
      csr(1'b0, 6'h01, '0, rd);        chk("cnt1_wrprio", rd, 64'h40);

      // Select beyond NUM_EVENTS disables the counter.
      csr(1'b1, 6'h14, 64'hFF, rd);
      csr(1'b0, 6'h14, '0, rd);        chk("sel4_trunc", rd, 64'h1F);
      event_i = '1;
      repeat (3) tick();
      event_i = NE'(1);
      csr(1'b0, 6'h04, '0, rd);        chk("cnt4_oor", rd, 64'd0);
      csr(1'b0, 6'h03, '0, rd);        chk("cnt3_all", rd, 64'd3);
      csr(1'b0, 6'h30, '0, rd);        chk("ovf_final", rd, 64'h04);
      chk("irq_pre_rst", 64'(irq), 64'd1);

      // Reset with an ack outstanding.
      csr_req = 1'b1; csr_we = 1'b0; csr_addr = 6'h03;
      tick();
      csr_req = 1'b0;
      chk("ack_pending", 64'(csr_ack), 64'd1);
      reset_l = 1'b0;
      #1;
      chk("mid_ack",   64'(csr_ack), 64'd0);
      chk("mid_rdata", csr_rdata,    64'd0);
      chk("mid_irq",   64'(irq),     64'd0);
      chk("mid_ready", 64'(ready),   64'd0);
      @(posedge clk); #1;
      reset_l = 1'b1;
      tick();                          chk("no_late_ack", 64'(csr_ack), 64'd0);
      repeat (7) tick();               chk("ready_again", 64'(ready), 64'd1);
      csr(1'b0, 6'h13, '0, rd);        chk("sel3_after", rd, 64'd3);
      csr(1'b0, 6'h03, '0, rd);        chk("cnt3_after", rd, 64'd0);
      csr(1'b0, 6'h30, '0, rd);        chk("ovf_after", rd, 64'd0);
      csr(1'b0, 6'h20, '0, rd);        chk("ctrl_after", rd, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lagarto_pmu_counter_bank.md
LAGARTO_PMU_COUNTER_BANK -- requirements
Module: lagarto_pmu_counter_bank

Interface
REQ-001 SHALL have parameter NUM_EVENTS, default 23: width of the event vector; event 0 is tied high by the integrator to count cycles.
REQ-002 SHALL have parameter NUM_COUNTERS, default 8, legal range 1..16: number of programmable counters.
REQ-003 SHALL have parameter CNT_WIDTH, default 64, legal range 1..64: counter width.
REQ-004 SHALL have parameter WAKE_CNT_WIDTH, default 16: wake-up delay counter width.
REQ-005 SHALL have port clk_i, input, 1 bit: clock.
REQ-006 SHALL have port reset_l, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port event_i, input, NUM_EVENTS bits: per-cycle event pulses.
REQ-008 SHALL have port csr_req_i, input, 1 bit: access request.
REQ-009 SHALL have port csr_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port csr_addr_i, input, 6 bits: [5:4] space (00 counter, 01 event-select, 10 control, 11 overflow status); [3:0] counter index.
REQ-011 SHALL have port csr_wdata_i, input, 64 bits: write data.
REQ-012 SHALL have port csr_rdata_o, output, 64 bits: read data, valid with csr_ack_o.
REQ-013 SHALL have port csr_ack_o, output, 1 bit: access completion pulse.
REQ-014 SHALL have port overflow_irq_o, output, 1 bit: level interrupt.
REQ-015 SHALL have port ready_o, output, 1 bit: wake-up delay elapsed; counting enabled.

Function
REQ-016 Wake-up counter SHALL increment each cycle from 0 after reset and saturate once its MSB is 1; ready_o SHALL equal that MSB (first high 2^(WAKE_CNT_WIDTH-1) cycles after reset release).
REQ-017 While ready_o=0: no counter SHALL increment; CSR accesses SHALL still be served.
REQ-018 Counter i SHALL increment by 1 in a cycle iff ready_o=1, inhibit[i]=0, sel[i]<NUM_EVENTS and event_i[sel[i]]=1.
REQ-019 sel[i] >= NUM_EVENTS SHALL disable counter i; no X-propagation.
REQ-020 Increment from 2^CNT_WIDTH-1 SHALL wrap to 0 and set ovf[i] in the same cycle.
REQ-021 Control register: bits [NUM_COUNTERS-1:0] SHALL be inhibit[]; bits [16+NUM_COUNTERS-1:16] SHALL be irq_en[]; all other bits SHALL read 0.
REQ-022 Event-select register i SHALL be $clog2(NUM_EVENTS) bits wide, zero-extended on read; write SHALL take the low bits.
REQ-023 Overflow status read SHALL return ovf[] in the low bits; a write SHALL clear each ovf[i] whose wdata bit is 1 (W1C).
REQ-024 overflow_irq_o SHALL be registered and equal |(ovf & irq_en) from the previous cycle.
REQ-025 Each csr_req_i SHALL produce csr_ack_o exactly one cycle later; back-to-back requests SHALL be accepted every cycle; no stall.
REQ-026 Read data SHALL be the register value at the request cycle, before that cycle's increment, zero-extended to 64 bits; csr_rdata_o SHALL be 0 when csr_ack_o=0.
REQ-027 Counter write SHALL load wdata[CNT_WIDTH-1:0] and SHALL take priority over a same-cycle increment; the write SHALL NOT set ovf.
REQ-028 Same-cycle W1C and new overflow of the same counter SHALL leave ovf[i]=1 (set wins).
REQ-029 Index >= NUM_COUNTERS in the counter or event-select space SHALL read 0, ignore writes, and still ack.
REQ-030 Control and overflow spaces SHALL ignore the index bits.

Reset
REQ-031 On reset_l=0, asynchronously: wake-up counter 0, ready_o 0, all counters 0, sel[i]=i mod NUM_EVENTS, inhibit 0, irq_en 0, ovf 0, csr_ack_o 0, csr_rdata_o 0, overflow_irq_o 0.
REQ-032 Reset asserted mid-access SHALL drop the pending ack; no ack SHALL be issued after release for that access.

Verification
REQ-033 Scenario: release reset, event_i[0]=1 constant, WAKE_CNT_WIDTH=4 -> ready_o rises 8 cycles after release; counter 0 reads N-8 after N cycles.
REQ-034 Scenario: CNT_WIDTH=8, write counter 2 = 0xFE, sel[2]=5, two pulses on event 5 -> counter 2 reads 0x00, ovf=0x04; irq_en[2]=1 -> overflow_irq_o=1 next cycle.
REQ-035 Scenario: W1C 0x04 to the overflow space coincident with counter 2 wrapping -> ovf[2] stays 1.
REQ-036 Scenario: write counter 1 = 0x100 while event pulses hit counter 1 the same cycle -> reads 0x100, not 0x101.
REQ-037 Scenario: inhibit[0]=1 for 10 cycles with event 0 high -> counter 0 unchanged; read index 15 with NUM_COUNTERS=8 -> ack with data 0.
REQ-038 Scenario: assert reset_l=0 mid-count with ack pending -> all outputs 0 immediately; sel[3] reads 3 after the wake-up delay.
